mc_sequencer: RTL and testbench

Multi-cycle sequencer for the single-issue MIPS-style datapath. It steps each instruction through fetch, decode, execute, memory and write-back phases using the decoder's level control signals and the ALU `zero` flag. It owns the memory request/acknowledge handshake, with a timeout, and produces the one-cycle write strobes for the instruction register, PC, memory and register file. It sits between the instruction decoder and the datapath/memory port.

---
 rtl/mc_pkg.sv | 24 ++
 rtl/mc_wait_timer.sv | 28 ++
 rtl/mc_sequencer.sv | 191 +++++++++++++++++++
 tb/tb_mc_sequencer.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/mc_pkg.sv
// mc_pkg: shared types and constants for the multi-cycle sequencer.
// Holds the state encoding, the opcodes the sequencer decodes itself,
// and the pc_src select encodings driven to the PC mux.
package mc_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd5
  } state_t;

  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_NOP   = 6'b111111;
  localparam logic [5:0] OP_STALL = 6'b000110;

  localparam logic [1:0] PC_INC = 2'b00;
  localparam logic [1:0] PC_BR  = 2'b01;
  localparam logic [1:0] PC_JMP = 2'b10;

endpackage

// File: rtl/mc_wait_timer.sv
// mc_wait_timer: memory-wait cycle counter with terminal-count flag.
// Ports: clk, rst (sync, active-low), clr (zero the count), inc (count up),
//        tc (count has reached LIMIT). Count saturates at LIMIT.
module mc_wait_timer #(
  parameter int LIMIT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic tc
);

  localparam int W = $clog2(LIMIT + 1);

  logic [W-1:0] cnt;

  assign tc = (cnt == W'(LIMIT));

  always_ff @(posedge clk) begin
    if (!rst || clr) begin
      cnt <= '0;
    end else if (inc && !tc) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/mc_sequencer.sv
// mc_sequencer: multi-cycle FETCH/DECODE/EXEC/MEM/WB control for the datapath.
// Ports: decoder controls + zero flag in; memory req/ack handshake with timeout;
//        one-cycle strobes ir_load, pc_write/pc_src, rf_we, instr_done, bus_err; state for debug.
module mc_sequencer
  import mc_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic       reg_write,
  input  logic       mem_read,
  input  logic       mem_write,
  input  logic       jump,
  input  logic       branch_on_eq,
  input  logic       branch_on_neq,
  input  logic       zero,
  input  logic       mem_ack,
  input  logic       hold,
  input  logic       resume,
  output logic       mem_req,
  output logic       mem_we,
  output logic       ir_load,
  output logic       pc_write,
  output logic [1:0] pc_src,
  output logic       alu_en,
  output logic       rf_we,
  output logic       instr_done,
  output logic       bus_err,
  output logic [2:0] state
);

  state_t     state_q, state_d;
  // Set once a fetch request has gone out, so a later hold cannot freeze it.
  logic       started_q, started_d;
  logic       tc, tmr_clr, tmr_inc;

  logic       mem_req_c, mem_we_c, ir_load_c, pc_write_c, alu_en_c;
  logic       rf_we_c, instr_done_c, bus_err_c;
  logic [1:0] pc_src_c;
  logic       is_br, br_taken;

  assign is_br    = (opcode == OP_BEQ) || (opcode == OP_BNE);
  assign br_taken = ((opcode == OP_BEQ) && branch_on_eq  &&  zero) ||
                    ((opcode == OP_BNE) && branch_on_neq && !zero);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= ST_FETCH;
      started_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      started_q <= started_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    started_d    = 1'b0;
    mem_req_c    = 1'b0;
    mem_we_c     = 1'b0;
    ir_load_c    = 1'b0;
    pc_write_c   = 1'b0;
    pc_src_c     = PC_INC;
    alu_en_c     = 1'b0;
    rf_we_c      = 1'b0;
    instr_done_c = 1'b0;
    bus_err_c    = 1'b0;

    case (state_q)
      ST_FETCH: begin
        if (started_q || !hold) begin
          mem_req_c = 1'b1;
          if (mem_ack) begin
            // Ack beats a coincident timeout.
            ir_load_c  = 1'b1;
            pc_write_c = 1'b1;
            state_d    = ST_DECODE;
          end else if (tc) begin
            // Abort: PC untouched, fetch is retried from scratch.
            mem_req_c = 1'b0;
            bus_err_c = 1'b1;
          end else begin
            started_d = 1'b1;
          end
        end
      end

      ST_DECODE: begin
        if (opcode == OP_NOP) begin
          instr_done_c = 1'b1;
          state_d      = ST_FETCH;
        end else if (opcode == OP_STALL) begin
          instr_done_c = 1'b1;
          state_d      = ST_HALT;
        end else begin
          state_d = ST_EXEC;
        end
      end

      ST_EXEC: begin
        alu_en_c = 1'b1;
        if (jump) begin
          pc_write_c   = 1'b1;
          pc_src_c     = PC_JMP;
          instr_done_c = 1'b1;
          state_d      = ST_FETCH;
        end else if (br_taken) begin
          pc_write_c   = 1'b1;
          pc_src_c     = PC_BR;
          instr_done_c = 1'b1;
          state_d      = ST_FETCH;
        end else if (is_br) begin
          instr_done_c = 1'b1;
          state_d      = ST_FETCH;
        end else if (mem_read || mem_write) begin
          state_d = ST_MEM;
        end else if (reg_write) begin
          state_d = ST_WB;
        end else begin
          instr_done_c = 1'b1;
          state_d      = ST_FETCH;
        end
      end

      ST_MEM: begin
        mem_req_c = 1'b1;
        mem_we_c  = mem_write;
        if (mem_ack) begin
          if (mem_read) begin
            state_d = ST_WB;
          end else begin
            instr_done_c = 1'b1;
            state_d      = ST_FETCH;
          end
        end else if (tc) begin
          mem_req_c = 1'b0;
          mem_we_c  = 1'b0;
          bus_err_c = 1'b1;
          state_d   = ST_FETCH;
        end
      end

      ST_WB: begin
        rf_we_c      = 1'b1;
        instr_done_c = 1'b1;
        state_d      = ST_FETCH;
      end

      ST_HALT: begin
        if (resume) begin
          state_d = ST_FETCH;
        end
      end

      default: begin
        state_d = ST_FETCH;
      end
    endcase
  end

  // Counter is held at zero whenever no request is outstanding, and zeroed on
  // any state change, so every FETCH/MEM entry (or retry) starts a fresh wait.
  assign tmr_clr = !mem_req_c || (state_d != state_q);
  assign tmr_inc = mem_req_c && !mem_ack;

  mc_wait_timer #(
    .LIMIT(MEM_TIMEOUT)
  ) u_wait_timer (
    .clk(clk),
    .rst(rst),
    .clr(tmr_clr),
    .inc(tmr_inc),
    .tc (tc)
  );

  // Reset is synchronous, so the registered state may still be mid-MEM in the
  // reset cycle; gate every output so nothing escapes while rst is low.
  assign mem_req    = rst & mem_req_c;
  assign mem_we     = rst & mem_we_c;
  assign ir_load    = rst & ir_load_c;
  assign pc_write   = rst & pc_write_c;
  assign pc_src     = rst ? pc_src_c : PC_INC;
  assign alu_en     = rst & alu_en_c;
  assign rf_we      = rst & rf_we_c;
  assign instr_done = rst & instr_done_c;
  assign bus_err    = rst & bus_err_c;
  assign state      = rst ? state_q : ST_FETCH;

endmodule

// File: tb/tb_mc_sequencer.sv
// tb_mc_sequencer: directed cycle-by-cycle check of mc_sequencer.
// Inputs change 1 ns after the rising edge; outputs are sampled on the falling edge.
// Expected output bundles per cycle are written out by hand.
module tb_mc_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] opcode;
  logic       reg_write, mem_read, mem_write, jump;
  logic       branch_on_eq, branch_on_neq, zero;
  logic       mem_ack, hold, resume;
  logic       mem_req, mem_we, ir_load, pc_write, alu_en, rf_we, instr_done, bus_err;
  logic [1:0] pc_src;
  logic [2:0] state;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  mc_sequencer #(.MEM_TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .opcode(opcode),
    .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write), .jump(jump),
    .branch_on_eq(branch_on_eq), .branch_on_neq(branch_on_neq), .zero(zero),
    .mem_ack(mem_ack), .hold(hold), .resume(resume),
    .mem_req(mem_req), .mem_we(mem_we), .ir_load(ir_load), .pc_write(pc_write),
    .pc_src(pc_src), .alu_en(alu_en), .rf_we(rf_we), .instr_done(instr_done),
    .bus_err(bus_err), .state(state)
  );

  // Output bundle: {state, req, we, ir_load, pc_write, pc_src, alu, rf_we, done, bus_err}
  logic [12:0] outs;
  assign outs = {state, mem_req, mem_we, ir_load, pc_write, pc_src, alu_en, rf_we, instr_done, bus_err};

  function automatic logic [12:0] ev(input int st, input bit req, input bit we, input bit irl,
                                     input bit pcw, input int src, input bit alu, input bit rfw,
                                     input bit done, input bit berr);
    logic [2:0] s3;
    logic [1:0] p2;
    s3 = st[2:0];
    p2 = src[1:0];
    return {s3, req, we, irl, pcw, p2, alu, rfw, done, berr};
  endfunction

  task automatic check_vec(input string tag, input logic [12:0] got, input logic [12:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got st=%0d req/we/irl/pcw=%b src=%b alu/rfw/done/berr=%b, want st=%0d req/we/irl/pcw=%b src=%b alu/rfw/done/berr=%b",
               tag, got[12:10], got[9:6], got[5:4], got[3:0], exp[12:10], exp[9:6], exp[5:4], exp[3:0]);
    end
  endtask

  // Sample this cycle's outputs, then advance to just after the next rising edge.
  task automatic cyc(input string tag, input logic [12:0] exp);
    @(negedge clk);
    check_vec(tag, outs, exp);
    @(posedge clk);
    #1;
  endtask

  task automatic set_instr(input logic [5:0] op, input bit rw, input bit mr, input bit mw,
                           input bit j, input bit beq, input bit bne, input bit z);
    opcode = op; reg_write = rw; mem_read = mr; mem_write = mw;
    jump = j; branch_on_eq = beq; branch_on_neq = bne; zero = z;
  endtask

  logic [12:0] F_ACK, F_REQ, DEC, EXE, IDLE0;

  initial begin
    F_ACK = ev(0, 1, 0, 1, 1, 0, 0, 0, 0, 0);
    F_REQ = ev(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    DEC   = ev(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    EXE   = ev(2, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    IDLE0 = ev(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    rst = 1'b0; mem_ack = 1'b0; hold = 1'b0; resume = 1'b0;
    set_instr(6'b000000, 1, 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    cyc("reset0", IDLE0);
    cyc("reset1", IDLE0);
    rst = 1'b1;

    // R-type add, zero-wait memory: 0,1,2,4
    mem_ack = 1'b1;
    cyc("rtype_fetch", F_ACK);
    cyc("rtype_dec", DEC);
    cyc("rtype_exec", EXE);
    cyc("rtype_wb", ev(4, 0, 0, 0, 0, 0, 0, 1, 1, 0));

    // BEQ taken
    set_instr(6'b000100, 0, 0, 0, 0, 1, 0, 1);
    cyc("beq_t_fetch", F_ACK);
    cyc("beq_t_dec", DEC);
    cyc("beq_t_exec", ev(2, 0, 0, 0, 1, 1, 1, 0, 1, 0));

    // BEQ not taken: retires in EXEC without PC update
    zero = 1'b0;
    cyc("beq_n_fetch", F_ACK);
    cyc("beq_n_dec", DEC);
    cyc("beq_n_exec", ev(2, 0, 0, 0, 0, 0, 1, 0, 1, 0));

    // R-type with stray branch flag and zero=1: no branch, WB
    set_instr(6'b000000, 1, 0, 0, 0, 1, 0, 1);
    cyc("rbr_fetch", F_ACK);
    cyc("rbr_dec", DEC);
    cyc("rbr_exec", EXE);
    cyc("rbr_wb", ev(4, 0, 0, 0, 0, 0, 0, 1, 1, 0));

    // Jump
    set_instr(6'b000010, 0, 0, 0, 1, 0, 0, 0);
    cyc("jmp_fetch", F_ACK);
    cyc("jmp_dec", DEC);
    cyc("jmp_exec", ev(2, 0, 0, 0, 1, 2, 1, 0, 1, 0));

    // Load with 3 wait cycles in MEM: 8 cycles total
    set_instr(6'b100011, 1, 1, 0, 0, 0, 0, 0);
    cyc("ld_fetch", F_ACK);
    cyc("ld_dec", DEC);
    cyc("ld_exec", EXE);
    mem_ack = 1'b0;
    for (int i = 0; i < 3; i++) cyc("ld_mem_wait", ev(3, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    mem_ack = 1'b1;
    cyc("ld_mem_ack", ev(3, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    cyc("ld_wb", ev(4, 0, 0, 0, 0, 0, 0, 1, 1, 0));

    // Fetch timeout with MEM_TIMEOUT=4: bus_err in cycle 5, fetch restarts
    set_instr(6'b111111, 0, 0, 0, 0, 0, 0, 0);
    mem_ack = 1'b0;
    for (int i = 0; i < 4; i++) cyc("to_wait", F_REQ);
    cyc("to_buserr", ev(0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    // Retry: ack lands exactly on the terminal-count cycle
    for (int i = 0; i < 4; i++) cyc("to_retry_wait", F_REQ);
    mem_ack = 1'b1;
    cyc("to_ack_wins", F_ACK);
    cyc("nop_dec", ev(1, 0, 0, 0, 0, 0, 0, 0, 1, 0));

    // hold before a request suppresses it; hold after it starts is ignored
    hold = 1'b1; mem_ack = 1'b0;
    cyc("hold0", IDLE0);
    cyc("hold1", IDLE0);
    hold = 1'b0;
    cyc("hold_rel", F_REQ);
    hold = 1'b1;
    cyc("hold_mid", F_REQ);
    mem_ack = 1'b1;
    cyc("hold_mid_ack", F_ACK);
    hold = 1'b0;
    cyc("hold_nop_dec", ev(1, 0, 0, 0, 0, 0, 0, 0, 1, 0));

    // Store interrupted by reset in MEM
    set_instr(6'b101011, 0, 0, 1, 0, 0, 0, 0);
    cyc("st_fetch", F_ACK);
    cyc("st_dec", DEC);
    cyc("st_exec", EXE);
    mem_ack = 1'b0;
    cyc("st_mem", ev(3, 1, 1, 0, 0, 0, 0, 0, 0, 0));
    rst = 1'b0;
    cyc("st_rst", IDLE0);
    rst = 1'b1;
    cyc("post_rst_req", F_REQ);

    // Store completing normally
    mem_ack = 1'b1;
    cyc("st2_fetch", F_ACK);
    cyc("st2_dec", DEC);
    cyc("st2_exec", EXE);
    cyc("st2_mem", ev(3, 1, 1, 0, 0, 0, 0, 0, 1, 0));

    // STALL: HALT until resume
    set_instr(6'b000110, 0, 0, 0, 0, 0, 0, 0);
    cyc("stall_fetch", F_ACK);
    cyc("stall_dec", ev(1, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    cyc("halt0", ev(5, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    cyc("halt1", ev(5, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    resume = 1'b1;
    cyc("halt_resume", ev(5, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    resume = 1'b0;
    cyc("after_resume", F_ACK);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
